// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counters and the init/run FSM states.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  localparam cnt_t CNT_INIT = WNT;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  function automatic cnt_t sat_update(cnt_t cnt, logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt_t'(cnt + 2'd1);
    end
    return (cnt == SNT) ? SNT : cnt_t'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Counter array: one registered lookup read, one combinational update read, one write port.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 10
) (
  input  logic                  clk,
  input  logic                  lookup_clr,
  input  logic [INDEX_BITS-1:0] lookup_idx,
  output cnt_t                  lookup_cnt,
  input  logic [INDEX_BITS-1:0] upd_idx,
  output cnt_t                  upd_cnt,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] widx,
  input  cnt_t                  wdata
);

  localparam int unsigned Depth = 1 << INDEX_BITS;

  cnt_t mem_q [Depth];
  cnt_t lookup_cnt_q;

  // Lookup register reads the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (lookup_clr) begin
      lookup_cnt_q <= SNT;
    end else begin
      lookup_cnt_q <= mem_q[lookup_idx];
    end
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign lookup_cnt = lookup_cnt_q;
  assign upd_cnt    = mem_q[upd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor with init sweep; gshare indexing when
// BRANCH_PREDICTOR_GSHARE_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned GHR_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           lookup_pc,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  output logic                  ready
);

  bp_state_t             state_q, state_d;
  logic [INDEX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [INDEX_BITS-1:0] pred_index_q;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic                  train;
  logic                  tbl_we;
  logic [INDEX_BITS-1:0] tbl_widx;
  cnt_t                  tbl_wdata;
  cnt_t                  upd_cnt;
  cnt_t                  lookup_cnt;
  logic                  unused_pc;

  assign unused_pc = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};
  assign train     = !rst && (state_q == RUN) && upd_valid;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_BITS-1:0]   ghr_q;
  logic [INDEX_BITS-1:0] ghr_ext;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = ghr_q;
  end

  // History is shifted only by resolved branches, so it never needs repair.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (train) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], upd_taken};
    end
  end

  assign lookup_idx = lookup_pc[INDEX_BITS+1:2] ^ ghr_ext;
`else
  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + INDEX_BITS'(1);
        if (init_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      pred_index_q <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      pred_index_q <= lookup_idx;
    end
  end

  // The init sweep owns the write port; training only gets it once in RUN.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_widx  = upd_index;
    tbl_wdata = sat_update(upd_cnt, upd_taken);
    if (!rst && (state_q == INIT)) begin
      tbl_we    = 1'b1;
      tbl_widx  = init_cnt_q;
      tbl_wdata = CNT_INIT;
    end else if (train) begin
      tbl_we = 1'b1;
    end
  end

  bp_counter_table #(
    .INDEX_BITS(INDEX_BITS)
  ) u_table (
    .clk       (clk),
    .lookup_clr(rst || (state_q == INIT)),
    .lookup_idx(lookup_idx),
    .lookup_cnt(lookup_cnt),
    .upd_idx   (upd_index),
    .upd_cnt   (upd_cnt),
    .we        (tbl_we),
    .widx      (tbl_widx),
    .wdata     (tbl_wdata)
  );

  assign prediction = lookup_cnt[1];
  assign pred_index = pred_index_q;
  assign ready      = (state_q == RUN);

endmodule
